// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive path.
// State encodings and default framing also used by the transmitter.
package uart_rx_ctrl_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial line in, bit strobes and frame status out.
// master = receive controller, slave = shift register / consumer.
interface uart_rx_ctrl_if;

    logic rx;
    logic bit_out;
    logic shift;
    logic rx_done;
    logic parity_err;
    logic frame_err;
    logic busy;

    modport master (
        input  rx,
        output bit_out,
        output shift,
        output rx_done,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  bit_out,
        input  shift,
        input  rx_done,
        input  parity_err,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
// Resets to RST_VAL so an idle-high line does not look active.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling,
// per-bit shift strobes, parity and stop-bit checking.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_ctrl_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);
    localparam logic          ODD     = (PARITY_ODD != 0);
    localparam logic          PEN     = (PARITY_EN != 0);

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_idx;
    logic          rx_s;
    logic          par;
    logic          perr;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            clk_cnt        <= '0;
            bit_idx        <= '0;
            par            <= 1'b0;
            perr           <= 1'b0;
            bus.bit_out    <= 1'b0;
            bus.shift      <= 1'b0;
            bus.rx_done    <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.shift      <= 1'b0;
            bus.rx_done    <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            // lags state by one cycle so busy drops after rx_done
            bus.busy       <= (state != S_IDLE);
            clk_cnt        <= clk_cnt + 1'b1;
            unique case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                        par   <= 1'b0;
                        perr  <= 1'b0;
                    end
                end
                S_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt     <= '0;
                        bus.bit_out <= rx_s;
                        bus.shift   <= 1'b1;
                        par         <= par ^ rx_s;
                        if (bit_idx == LAST) begin
                            bit_idx <= '0;
                            state   <= PEN ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        perr    <= ((par ^ rx_s) != ODD);
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            bus.rx_done    <= 1'b1;
                            bus.parity_err <= perr;
                            state          <= S_IDLE;
                        end else begin
                            bus.frame_err  <= 1'b1;
                            state          <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus random traffic
// against a frame-level model, on a no-parity and an even-parity DUT.
module tb_uart_rx_ctrl;

    localparam int C  = 16;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rx_line = 2'b11;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ctrl_if if0 ();
    uart_rx_ctrl_if if1 ();

    assign if0.rx = rx_line[0];
    assign if1.rx = rx_line[1];

    uart_rx_ctrl #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (DB),
        .PARITY_EN    (0),
        .PARITY_ODD   (0)
    ) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    uart_rx_ctrl #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (DB),
        .PARITY_EN    (1),
        .PARITY_ODD   (0)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    logic [1:0] sh, dn, pe, fe, bz, bo;
    logic [1:0] psh = '0, pdn = '0, pfe = '0, pbz = '0;

    assign sh = {if1.shift, if0.shift};
    assign dn = {if1.rx_done, if0.rx_done};
    assign pe = {if1.parity_err, if0.parity_err};
    assign fe = {if1.frame_err, if0.frame_err};
    assign bz = {if1.busy, if0.busy};
    assign bo = {if1.bit_out, if0.bit_out};

    // observed events
    logic bitq  [2][$];
    int   stq   [2][$];
    logic doneq [2][$];
    int   dcq   [2][$];
    int   ferr_n [2];
    int   busy_fall [2];
    int   viol = 0;

    // expected events
    logic exp_bits [2][$];
    logic exp_perr [2][$];
    int   exp_ferr [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            ferr_n[i]    = 0;
            busy_fall[i] = 0;
            exp_ferr[i]  = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sh[i]) begin
                bitq[i].push_back(bo[i]);
                stq[i].push_back(cyc);
            end
            if (dn[i]) begin
                doneq[i].push_back(pe[i]);
                dcq[i].push_back(cyc);
            end
            if (fe[i]) ferr_n[i]++;
            if (pe[i] && !dn[i]) viol++;
            if (pbz[i] && !bz[i]) busy_fall[i] = cyc;
            if ((sh[i] && psh[i]) || (dn[i] && pdn[i]) ||
                (fe[i] && pfe[i])) viol++;
        end
        psh = sh;
        pdn = dn;
        pfe = fe;
        pbz = bz;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic par_err(input logic [7:0] d, input int nb,
                                     input logic pbit, input logic odd);
        int ones = 0;
        for (int k = 0; k < nb; k++) ones += int'(d[k]);
        return ((ones % 2 == 1) ^ pbit) != odd;
    endfunction

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            bitq[i].delete();
            stq[i].delete();
            doneq[i].delete();
            dcq[i].delete();
            exp_bits[i].delete();
            exp_perr[i].delete();
            ferr_n[i]   = 0;
            exp_ferr[i] = 0;
        end
    endtask

    // Caller is at a negedge; returns at a negedge. e = edge that
    // first samples the start bit.
    task automatic send(input int s, input logic [7:0] d,
                        input logic pen, input logic pbit,
                        input logic stp, output int e);
        rx_line[s] = 1'b0;
        e = cyc + 1;
        repeat (C) @(negedge clk);
        for (int k = 0; k < DB; k++) begin
            rx_line[s] = d[k];
            exp_bits[s].push_back(d[k]);
            repeat (C) @(negedge clk);
        end
        if (pen) begin
            rx_line[s] = pbit;
            repeat (C) @(negedge clk);
        end
        rx_line[s] = stp;
        if (stp) begin
            exp_perr[s].push_back(pen ? par_err(d, DB, pbit, 1'b0)
                                      : 1'b0);
        end else begin
            exp_ferr[s]++;
        end
        repeat (C) @(negedge clk);
    endtask

    task automatic verify(input string tag, input int s);
        int nb, nd;
        chk({tag, "_nshift"}, bitq[s].size(), exp_bits[s].size());
        nb = bitq[s].size() < exp_bits[s].size() ?
             bitq[s].size() : exp_bits[s].size();
        for (int i = 0; i < nb; i++)
            chk({tag, "_bit"}, bitq[s][i], exp_bits[s][i]);
        chk({tag, "_ndone"}, doneq[s].size(), exp_perr[s].size());
        nd = doneq[s].size() < exp_perr[s].size() ?
             doneq[s].size() : exp_perr[s].size();
        for (int i = 0; i < nd; i++)
            chk({tag, "_perr"}, doneq[s][i], exp_perr[s][i]);
        chk({tag, "_ferr"}, ferr_n[s], exp_ferr[s]);
        clr();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [7:0] d;
        logic       pb;

        repeat (3) @(negedge clk);
        chk("rst_busy",   bz, 2'b00);
        chk("rst_shift",  sh, 2'b00);
        chk("rst_done",   dn, 2'b00);
        chk("rst_perr",   pe, 2'b00);
        chk("rst_ferr",   fe, 2'b00);
        chk("rst_bitout", bo, 2'b00);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        clr();

        // baseline 0x55 with exact timing
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, e);
        repeat (2 * C) @(negedge clk);
        if (stq[0].size() == DB) begin
            for (int k = 0; k < DB; k++)
                chk("t1_shift_t", stq[0][k], e + 2 + C/2 + (k+1)*C);
        end
        if (dcq[0].size() == 1) begin
            chk("t1_done_t", dcq[0][0], e + 2 + C/2 + (DB+1)*C);
            chk("t1_busy_fall", busy_fall[0], dcq[0][0] + 1);
        end
        verify("t1", 0);

        // even parity, good then bad parity bit
        send(1, 8'hA3, 1'b1, 1'b0, 1'b1, e);
        repeat (C) @(negedge clk);
        send(1, 8'hA3, 1'b1, 1'b1, 1'b1, e);
        repeat (2 * C) @(negedge clk);
        chk("t2_perr_exp", {exp_perr[1][0], exp_perr[1][1]}, 2'b01);
        verify("t2", 1);

        // framing error then held-low break
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, e);
        repeat (39 * C) @(negedge clk);
        chk("t3_busy_break", bz[0], 1'b1);
        rx_line[0] = 1'b1;
        repeat (C) @(negedge clk);
        chk("t3_busy_idle", bz[0], 1'b0);
        send(0, 8'h01, 1'b0, 1'b0, 1'b1, e);
        repeat (2 * C) @(negedge clk);
        verify("t3", 0);

        // false start shorter than half a bit
        rx_line[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (2 * C) @(negedge clk);
        chk("t4_busy", bz[0], 1'b0);
        verify("t4", 0);

        // reset after the third shift
        fork
            send(0, 8'hFF, 1'b0, 1'b0, 1'b1, e);
            begin
                for (int i = 0; i < 400 && bitq[0].size() < 3; i++) begin
                    @(negedge clk);
                    #1;
                end
                chk("t5_reach3", bitq[0].size(), 3);
                reset = 1'b1;
                @(negedge clk);
                #1;
                chk("t5_shift", sh[0], 1'b0);
                chk("t5_busy", bz[0], 1'b0);
                reset = 1'b0;
            end
        join
        repeat (2 * C) @(negedge clk);
        chk("t5_nshift_abort", bitq[0].size(), 3);
        chk("t5_ndone_abort", doneq[0].size(), 0);
        clr();
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1, e);
        repeat (2 * C) @(negedge clk);
        verify("t5", 0);

        // back-to-back with no idle gap
        send(0, 8'h12, 1'b0, 1'b0, 1'b1, e);
        send(0, 8'h34, 1'b0, 1'b0, 1'b1, e);
        repeat (2 * C) @(negedge clk);
        verify("t6", 0);

        // random traffic on both instances
        for (int n = 0; n < 16; n++) begin
            d  = 8'($urandom);
            pb = 1'($urandom);
            send(1, d, 1'b1, pb, 1'b1, e);
            repeat ($urandom_range(0, 2 * C)) @(negedge clk);
        end
        repeat (2 * C) @(negedge clk);
        verify("rnd_par", 1);

        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            send(0, d, 1'b0, 1'b0, 1'b1, e);
            repeat ($urandom_range(0, C)) @(negedge clk);
        end
        repeat (2 * C) @(negedge clk);
        verify("rnd_nopar", 0);

        chk("strobe_rules", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
